// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage register (head + skid) with valid/ready on both
// sides. in_ready depends only on state flops (and reset), so there is no
// combinational path from out_ready back to in_ready.
module pipe_skid_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned TYPE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TYPE_W-1:0] in_type,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TYPE_W-1:0] out_type,
  output logic [1:0]        occupancy
);

  // State bits are {main_v, skid_v}; skid-only is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [TYPE_W-1:0] main_type_q, skid_type_q;

  logic main_v, skid_v;
  logic acc, pop;
  logic main_we, main_from_skid, skid_we;

  assign main_v = state_q[1];
  assign skid_v = state_q[0];

  assign in_ready  = rst & ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_data_q;
  assign out_type  = main_type_q & {TYPE_W{main_v}};
  assign occupancy = 2'({1'b0, main_v}) + 2'({1'b0, skid_v});

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // Next-state and payload write enables; flush overrides every other event.
  always_comb begin
    state_d        = state_q;
    main_we        = 1'b0;
    main_from_skid = 1'b0;
    skid_we        = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            main_we = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_we = 1'b1;
          end else if (acc) begin
            skid_we = 1'b1;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_we        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Valid bits: the only reset state in the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers: unreset, written only on the listed transitions.
  always_ff @(posedge clk) begin
    if (main_we) begin
      main_data_q <= main_from_skid ? skid_data_q : in_data;
      main_type_q <= main_from_skid ? skid_type_q : in_type;
    end
    if (skid_we) begin
      skid_data_q <= in_data;
      skid_type_q <= in_type;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic, all checked
// against a FIFO-queue reference model of at most two entries.
module tb_pipe_skid_reg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned TYPE_W = 8;
  localparam int unsigned CW     = DATA_W + TYPE_W;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [TYPE_W-1:0] in_type;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TYPE_W-1:0] out_type;
  logic [1:0]        occupancy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: entries in arrival order, each {type, data}.
  logic [CW-1:0] mq[$];

  pipe_skid_reg #(.DATA_W(DATA_W), .TYPE_W(TYPE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_type   (in_type),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_type  (out_type),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare all DUT outputs against the queue model.
  task automatic check_model();
    logic [CW-1:0] head;
    check("out_valid", CW'(out_valid), CW'(mq.size() > 0));
    check("occupancy", CW'(occupancy), CW'(mq.size()));
    check("in_ready", CW'(in_ready), CW'(mq.size() < 2));
    if (mq.size() > 0) begin
      head = mq[0];
      check("out_data", CW'(out_data), CW'(head[DATA_W-1:0]));
      check("out_type", CW'(out_type), CW'(head[CW-1:DATA_W]));
    end else begin
      check("out_type_idle", CW'(out_type), CW'(0));
    end
  endtask

  // One cycle: inputs already driven; check, clock, update model, return at negedge.
  task automatic step();
    bit            acc, pop;
    logic [CW-1:0] ent;
    #1;
    check_model();
    acc = in_valid && (mq.size() < 2);
    pop = out_ready && (mq.size() > 0);
    ent = {in_type, in_data};
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (acc) mq.push_back(ent);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [TYPE_W-1:0] t,
                       input bit rdy, input bit fl);
    in_valid  = v;
    in_data   = d;
    in_type   = t;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    bit r0, r1, sv;
    logic [TYPE_W-1:0] t1;
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    check("rst_out_valid", CW'(out_valid), CW'(0));
    check("rst_in_ready", CW'(in_ready), CW'(0));
    check("rst_occ", CW'(occupancy), CW'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_in_ready", CW'(in_ready), CW'(1));

    // Streaming: 8 entries with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      t1 = TYPE_W'(1) << (i - 1);
      drive(1'b1, DATA_W'(i), t1, 1'b1, 1'b0);
      step();
      check("stream_occ", CW'(occupancy), CW'(1));
      check("stream_data", CW'(out_data), CW'(i));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check("stream_drain", CW'(out_valid), CW'(0));

    // Skid: hold A, stall, offer B then C.
    drive(1'b1, DATA_W'('hA), 8'h01, 1'b1, 1'b0); step();
    drive(1'b1, DATA_W'('hB), 8'h02, 1'b0, 1'b0); step();
    check("skid_occ2", CW'(occupancy), CW'(2));
    check("skid_rdy0", CW'(in_ready), CW'(0));
    drive(1'b1, DATA_W'('hC), 8'h04, 1'b0, 1'b0); step();
    check("skid_hold_A", CW'(out_data), CW'('hA));
    check("skid_hold_occ", CW'(occupancy), CW'(2));
    out_ready = 1'b1;
    #1 check("skid_out_A", CW'(out_data), CW'('hA));
    step();
    check("skid_out_B", CW'(out_data), CW'('hB));
    step();
    check("skid_out_C", CW'(out_data), CW'('hC));
    in_valid = 1'b0;
    step();
    check("skid_empty", CW'(out_valid), CW'(0));

    // Flush in TWO with a pop in the same cycle.
    drive(1'b1, DATA_W'('h11), 8'h10, 1'b0, 1'b0); step();
    drive(1'b1, DATA_W'('h22), 8'h20, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    #1 check("flush_head", CW'(out_data), CW'('h11));
    step();
    flush = 1'b0;
    #1;
    check("flush_valid", CW'(out_valid), CW'(0));
    check("flush_type", CW'(out_type), CW'(0));
    check("flush_occ", CW'(occupancy), CW'(0));

    // Flush from ONE discards the entry offered in that cycle.
    drive(1'b1, DATA_W'('h33), 8'h40, 1'b0, 1'b0); step();
    drive(1'b1, DATA_W'('h44), 8'h80, 1'b0, 1'b1); step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_discard", CW'(out_valid), CW'(0));
    end

    // Flush in EMPTY is a no-op.
    drive(1'b0, '0, '0, 1'b0, 1'b1); step();
    flush = 1'b0;
    #1 check("flush_empty", CW'(occupancy), CW'(0));

    // Asynchronous reset mid-cycle while in TWO.
    @(negedge clk);
    drive(1'b1, DATA_W'('h55), 8'h01, 1'b0, 1'b0); step();
    drive(1'b1, DATA_W'('h66), 8'h02, 1'b0, 1'b0); step();
    check("pre_rst_occ", CW'(occupancy), CW'(2));
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_valid", CW'(out_valid), CW'(0));
    check("arst_type", CW'(out_type), CW'(0));
    check("arst_occ", CW'(occupancy), CW'(0));
    check("arst_rdy", CW'(in_ready), CW'(0));
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arel_rdy", CW'(in_ready), CW'(1));
    check("arel_valid", CW'(out_valid), CW'(0));

    // Random traffic against the queue model.
    for (int c = 0; c < 10000; c++) begin
      t1 = TYPE_W'(1) << $urandom_range(0, TYPE_W - 1);
      drive($urandom_range(0, 9) < 6, {$urandom, $urandom, $urandom, $urandom}, t1,
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
      sv = out_ready;
      out_ready = 1'b0;
      #1 r0 = in_ready;
      out_ready = 1'b1;
      #1 r1 = in_ready;
      out_ready = sv;
      check("rdy_indep", CW'(r0), CW'(r1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised, two-entry pipeline stage register with a full valid/ready handshake on both sides, a registered upstream ready, synchronous flush, and valid-gated type decoding. It generalises the fixed-field ID→EX register into a reusable stage between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM). The skid entry lets `in_ready` come from a flop, so no combinational path runs from `out_ready` to `in_ready`.

## Interface
- `DATA_W`, default 128: width of the opaque payload (PC, operands, immediates, rd, and so on).
- `TYPE_W`, default 8: width of the one-hot instruction-type field. It is carried separately so that it can be masked.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `flush`  in  1  synchronous kill of all held and incoming entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept an entry. Driven by state flops only.
- `in_data`  in  DATA_W  upstream payload.
- `in_type`  in  TYPE_W  upstream instruction type.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_data`  out  DATA_W  head payload.
- `out_type`  out  TYPE_W  head type, ANDed with `out_valid`.
- `occupancy`  out  2  number of held entries, 0 to 2.

## Operation
- Storage is a main (head) register and a skid register. Only `main_v` and `skid_v` are reset. Payload registers are not reset.
- Encoded state:
  - EMPTY: `main_v`=0, `skid_v`=0.
  - ONE: `main_v`=1, `skid_v`=0.
  - TWO: `main_v`=1, `skid_v`=1.
  - A state with only `skid_v` set is unreachable.
- `in_ready` = `rst` deasserted and state != TWO.
- Handshake definitions:
  - `acc` = `in_valid` & `in_ready`.
  - `pop` = `out_valid` & `out_ready`.
- `out_valid` = `main_v`. `out_data` = main payload. `out_type` = main type & {TYPE_W{`main_v`}}.
- `occupancy` = `main_v` + `skid_v`.
- Transitions when `flush`=0:
  - EMPTY, `acc`: main <= in, go to ONE.
  - EMPTY, no `acc`: stay in EMPTY.
  - ONE, `acc` and `pop`: main <= in, stay in ONE.
  - ONE, `acc` only: skid <= in, go to TWO.
  - ONE, `pop` only: go to EMPTY.
  - TWO, `pop`: main <= skid, go to ONE. `acc` is impossible here because `in_ready`=0.
  - TWO, no `pop`: hold everything.
- `flush`=1 has priority over all other events:
  - Next state is EMPTY.
  - Any `acc` in the same cycle is discarded.
  - A `pop` in the flush cycle still completes. Outputs in the flush cycle are unaffected; the flush takes effect at the edge.
- Ordering is strict FIFO: the skid entry is always older than any later input.
- Payload registers are written only on the transitions listed above and hold otherwise.
- `out_data` is only meaningful while `out_valid`=1.

## Timing
- Reset (`rst` low, asynchronous):
  - `main_v`=0 and `skid_v`=0 immediately.
  - `out_valid`=0, `out_type`=0, `occupancy`=0, `in_ready`=0.
  - On release: `in_ready`=1 in the first cycle after `rst` returns high.
- Latency: an entry accepted at edge k is visible on `out_*` from edge k to the next edge (1 cycle). There is no combinational in→out path.
- Throughput: with `out_ready` held at 1, the stage accepts 1 entry per cycle indefinitely and stays in ONE.
- Backpressure:
  - After `out_ready` falls, the stage accepts at most one more entry, then `in_ready` falls at the following edge.
  - After `out_ready` rises in TWO, `in_ready` rises one edge later.
- Reset asserted mid-operation: both entries are lost and there is no spurious `out_valid` after release.
- Flush with `acc` in TWO cannot occur, because `in_ready`=0 in TWO.
- Flush in EMPTY is a no-op.

## Test plan
- Reset and release: pull `rst` low mid-cycle while in TWO. Required: `out_valid`=0, `out_type`=0x00, `occupancy`=0 with no clock edge. After release, `in_ready`=1.
- Streaming: drive 8 entries, data 0x1…0x8 and type 0x01…0x80, with `out_ready`=1. Required: outputs appear in order one cycle later, 1 per cycle, `occupancy` stays at 1.
- Skid: in ONE holding 0xA, drop `out_ready` and offer 0xB. Required: 0xB is accepted, `occupancy`=2, `in_ready`=0 next cycle, and 0xC is held off. Raise `out_ready`. Required: 0xA then 0xB then 0xC are output with no loss or duplication.
- Flush: in TWO, assert `flush` together with `out_ready`=1. Required: the head pops that cycle, then `out_valid`=0, `out_type`=0, `occupancy`=0. An entry offered in a flush cycle taken from ONE never appears at the output.
- Random: 10k cycles of random `in_valid`, `out_ready` and `flush` checked against a scoreboard queue. Required: no reordering, no drops except by flush, and `in_ready` never depends combinationally on `out_ready`.
